// File: rtl/hazard_sched_pkg.sv
// hazard_sched_pkg: shared types and constants for the pipeline sequencing controller
package hazard_sched_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] X0 = 5'd0;

    typedef enum logic [1:0] {INIT, RUN, MEM_WAIT, ERR} state_e;

    typedef struct packed {
        logic en;
        logic clr;
    } stage_ctrl_t;

    function automatic stage_ctrl_t sc(input logic e, input logic c);
        return '{en: e, clr: c};
    endfunction

endpackage

// File: rtl/hazard_sched_sat_counter.sv
// sat_counter: counter that increments on inc and holds at all-ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // count up until every bit is set, then hold
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (inc && !(&cnt)) cnt <= cnt + 1'b1;

endmodule

// File: rtl/hazard_sched.sv
// hazard_sched: stall/flush sequencing for the 5-stage RV32I pipeline
module hazard_sched
    import hazard_sched_pkg::*;
#(
    parameter int FLUSH_CYC = 2,
    parameter int MAX_WAIT  = 15,
    parameter int CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_is_load,
    input  logic                  ex_redirect,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  idex_en,
    output logic                  exmem_en,
    output logic                  memwb_en,
    output logic                  ifid_clr,
    output logic                  idex_clr,
    output logic                  exmem_clr,
    output logic                  memwb_clr,
    output logic                  timeout_err,
    output logic [CNT_W-1:0]      stall_cnt
);

    state_e      state, state_nxt;
    logic [3:0]  flush_cnt;
    logic [7:0]  wait_cnt, wait_nxt;
    stage_ctrl_t ifid, idex, exmem, memwb;
    logic        mem_stall, load_use, hold, go_err, flush_done, stall_inc;

    assign mem_stall  = mem_req & ~mem_ready;
    assign load_use   = ex_is_load & (ex_rd != X0) &
                        ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    // a pending memory access freezes everything upstream of WB; it outranks redirect and load-use
    assign hold       = (state == RUN & mem_stall) | (state == MEM_WAIT & ~mem_ready);
    assign wait_nxt   = (state == RUN) ? 8'd1 : wait_cnt + 8'd1;
    assign go_err     = wait_nxt == 8'(MAX_WAIT);
    assign flush_done = flush_cnt == 4'(FLUSH_CYC - 1);
    assign stall_inc  = (state == RUN | state == MEM_WAIT) & ~pc_en;

    // state, flush/wait counters and the sticky timeout flag
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state       <= INIT;
            flush_cnt   <= '0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            flush_cnt   <= (state == INIT && !flush_done) ? flush_cnt + 4'd1 : flush_cnt;
            wait_cnt    <= hold ? wait_nxt : '0;
            timeout_err <= state_nxt == ERR;
        end

    // next state: flush after reset, track mem waits, trap on timeout
    always_comb begin
        state_nxt = state;
        case (state)
            INIT:          state_nxt = flush_done ? RUN : INIT;
            RUN, MEM_WAIT: state_nxt = hold ? (go_err ? ERR : MEM_WAIT) : RUN;
            default:       state_nxt = ERR;
        endcase
    end

    // Mealy stage controls: freeze, redirect kill, load-use bubble, or free run
    always_comb begin
        if (state == INIT) begin
            pc_en = 1'b0; ifid = sc(0, 1); idex = sc(0, 1); exmem = sc(0, 1); memwb = sc(0, 1);
        end else if (state == ERR) begin
            pc_en = 1'b0; ifid = sc(0, 0); idex = sc(0, 0); exmem = sc(0, 0); memwb = sc(0, 0);
        end else if (hold) begin
            pc_en = 1'b0; ifid = sc(0, 0); idex = sc(0, 0); exmem = sc(0, 0); memwb = sc(1, 1);
        end else if (ex_redirect) begin
            pc_en = 1'b1; ifid = sc(1, 1); idex = sc(1, 1); exmem = sc(1, 0); memwb = sc(1, 0);
        end else if (load_use) begin
            pc_en = 1'b0; ifid = sc(0, 0); idex = sc(1, 1); exmem = sc(1, 0); memwb = sc(1, 0);
        end else begin
            pc_en = 1'b1; ifid = sc(1, 0); idex = sc(1, 0); exmem = sc(1, 0); memwb = sc(1, 0);
        end
    end

    assign ifid_en   = ifid.en;
    assign idex_en   = idex.en;
    assign exmem_en  = exmem.en;
    assign memwb_en  = memwb.en;
    assign ifid_clr  = ifid.clr;
    assign idex_clr  = idex.clr;
    assign exmem_clr = exmem.clr;
    assign memwb_clr = memwb.clr;

    sat_counter #(.W(CNT_W)) u_stall (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .cnt   (stall_cnt)
    );

endmodule

// File: tb/tb_hazard_sched.sv
// tb_hazard_sched: directed checks of hazard_sched stage controls, counters and timeout
module tb_hazard_sched;

    localparam logic [8:0] C_INIT = 9'b00000_1111;
    localparam logic [8:0] C_RUN  = 9'b11111_0000;
    localparam logic [8:0] C_HOLD = 9'b00001_0001;
    localparam logic [8:0] C_REDR = 9'b11111_1100;
    localparam logic [8:0] C_LU   = 9'b00111_0100;
    localparam logic [8:0] C_ERR  = 9'b00000_0000;

    logic clk = 0, rst_n = 0;
    logic [4:0] id_rs1 = 0, id_rs2 = 0, ex_rd = 0;
    logic id_use_rs1 = 0, id_use_rs2 = 0, ex_is_load = 0, ex_redirect = 0;
    logic mem_req = 0, mem_ready = 0, mem_req_b = 0;

    logic a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_ifidc, a_idexc, a_exmemc, a_memwbc, a_to;
    logic b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_ifidc, b_idexc, b_exmemc, b_memwbc, b_to;
    logic [15:0] a_cnt;
    logic [1:0]  b_cnt;
    logic [8:0]  a_ctl, b_ctl;

    int total = 0, bad = 0;

    assign a_ctl = {a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_ifidc, a_idexc, a_exmemc, a_memwbc};
    assign b_ctl = {b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_ifidc, b_idexc, b_exmemc, b_memwbc};

    always #5 clk = ~clk;

    hazard_sched dut_a (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_is_load(ex_is_load), .ex_redirect(ex_redirect), .mem_req(mem_req),
        .mem_ready(mem_ready), .pc_en(a_pc), .ifid_en(a_ifid), .idex_en(a_idex),
        .exmem_en(a_exmem), .memwb_en(a_memwb), .ifid_clr(a_ifidc), .idex_clr(a_idexc),
        .exmem_clr(a_exmemc), .memwb_clr(a_memwbc), .timeout_err(a_to), .stall_cnt(a_cnt)
    );

    hazard_sched #(.MAX_WAIT(3), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_is_load(ex_is_load), .ex_redirect(ex_redirect), .mem_req(mem_req_b),
        .mem_ready(mem_ready), .pc_en(b_pc), .ifid_en(b_ifid), .idex_en(b_idex),
        .exmem_en(b_exmem), .memwb_en(b_memwb), .ifid_clr(b_ifidc), .idex_clr(b_idexc),
        .exmem_clr(b_exmemc), .memwb_clr(b_memwbc), .timeout_err(b_to), .stall_cnt(b_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // drive one cycle of inputs at the falling edge, settle, then the caller checks
    task automatic cyc(input logic ld, input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                       input logic u1, input logic u2, input logic rdr,
                       input logic mq, input logic mr, input logic mqb);
        @(negedge clk);
        ex_is_load = ld; ex_rd = rd; id_rs1 = r1; id_rs2 = r2;
        id_use_rs1 = u1; id_use_rs2 = u2; ex_redirect = rdr;
        mem_req = mq; mem_ready = mr; mem_req_b = mqb;
        #1;
    endtask

    task automatic idle;
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            idle;
            chk("rst_ctl", a_ctl, C_INIT);
        end
        chk("rst_cnt", a_cnt, 0);
        chk("rst_to", b_to, 0);
        rst_n = 1; #1;
        chk("flush0", a_ctl, C_INIT);
        idle; chk("flush1", a_ctl, C_INIT);
        idle; chk("run", a_ctl, C_RUN);
        chk("run_b", b_ctl, C_RUN);
        chk("run_cnt", a_cnt, 0);

        cyc(1, 5, 0, 5, 0, 1, 0, 0, 0, 0); chk("lu_rs2", a_ctl, C_LU);
        idle; chk("lu_once", a_ctl, C_RUN); chk("lu_cnt", a_cnt, 1);
        cyc(1, 0, 0, 0, 0, 1, 0, 0, 0, 0); chk("lu_x0", a_ctl, C_RUN);
        cyc(1, 7, 7, 0, 1, 0, 0, 0, 0, 0); chk("lu_rs1", a_ctl, C_LU);
        cyc(1, 7, 7, 0, 0, 0, 0, 0, 0, 0); chk("lu_nouse", a_ctl, C_RUN);
        chk("lu_cnt2", a_cnt, 2);
        chk("lu_cnt_b", b_cnt, 2);

        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0); chk("redir", a_ctl, C_REDR);
        idle; chk("redir_cnt", a_cnt, 2);

        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
            chk("mw_hold", a_ctl, C_HOLD);
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 0); chk("mw_rel", a_ctl, C_RUN);
        idle; chk("mw_cnt", a_cnt, 6);

        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
            chk("sr_hold", a_ctl, C_HOLD);
            chk("sr_b", b_ctl, C_REDR);
        end
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 1, 0); chk("sr_rel", a_ctl, C_REDR);
        idle; chk("sr_cnt", a_cnt, 9);

        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); chk("to_h1", b_ctl, C_HOLD);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); chk("to_h2", b_ctl, C_HOLD); chk("to_sat", b_cnt, 3);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); chk("to_h3", b_ctl, C_HOLD); chk("to_noerr", b_to, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); chk("to_err", b_ctl, C_ERR); chk("to_flag", b_to, 1);
        chk("to_a", a_ctl, C_RUN);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 1, 0); chk("to_stick", b_ctl, C_ERR);
        idle; chk("to_flag2", b_to, 1); chk("to_cnt", b_cnt, 3); chk("to_a_cnt", a_cnt, 9);

        cyc(1, 5, 0, 5, 0, 1, 0, 1, 0, 0); chk("lurel_h", a_ctl, C_HOLD);
        cyc(1, 5, 0, 5, 0, 1, 0, 1, 1, 0); chk("lurel_lu", a_ctl, C_LU);
        idle; chk("lurel_run", a_ctl, C_RUN); chk("lurel_cnt", a_cnt, 11);
        chk("a_to", a_to, 0);

        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); chk("mr_h1", a_ctl, C_HOLD);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); chk("mr_h2", a_ctl, C_HOLD);
        rst_n = 0; #1;
        chk("mr_ctl", a_ctl, C_INIT); chk("mr_cnt", a_cnt, 0);
        chk("mr_b", b_ctl, C_INIT); chk("mr_bto", b_to, 0); chk("mr_bcnt", b_cnt, 0);
        idle;
        rst_n = 1; #1;
        chk("mr_f0", a_ctl, C_INIT);
        idle; chk("mr_f1", a_ctl, C_INIT);
        idle; chk("mr_run", a_ctl, C_RUN); chk("mr_brun", b_ctl, C_RUN);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
